// File: rtl/axi_bram_responder_if.sv
// AXI4 write/read channel bundle between the GMII top's master port and the
// BRAM responder. Full 32-bit data beats, no size/lock/cache/prot/qos sideband.
interface axi_bram_responder_if #(
  parameter int ID_W   = 4,
  parameter int ADDR_W = 32
);
  logic [ID_W-1:0]   awid;
  logic [ADDR_W-1:0] awaddr;
  logic [7:0]        awlen;
  logic [1:0]        awburst;
  logic              awvalid;
  logic              awready;

  logic [31:0]       wdata;
  logic [3:0]        wstrb;
  logic              wlast;
  logic              wvalid;
  logic              wready;

  logic [ID_W-1:0]   bid;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;

  logic [ID_W-1:0]   arid;
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic [1:0]        arburst;
  logic              arvalid;
  logic              arready;

  logic [ID_W-1:0]   rid;
  logic [31:0]       rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rvalid;
  logic              rready;

  modport slave (
    input  awid, awaddr, awlen, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arburst, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );

  modport master (
    output awid, awaddr, awlen, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arburst, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );
endinterface

// File: rtl/axi_bram_responder.sv
// AXI4 slave backed by block RAM; one burst at a time, 1 beat/clk on W and R.
// Stand-in for the DDR3 controller behind the GMII top's AXI master port.
module axi_bram_responder #(
  parameter int ID_W      = 4,
  parameter int ADDR_W    = 32,
  parameter int MEM_WORDS = 1024,
  parameter int RD_PIPE   = 1
) (
  input  logic                  i_sys_clk,
  input  logic                  i_sys_rst_n,
  axi_bram_responder_if.slave   s_axi
);
  localparam int IDX_W = $clog2(MEM_WORDS);
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {IDLE, WDATA, WRESP, RADDR, RDATA} state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [7:0]        len_q, len_d;
  logic [1:0]        burst_q, burst_d;
  logic [IDX_W-1:0]  idx_q, idx_d, idx_nxt;
  logic              err_q, err_d;
  logic [8:0]        cnt_q, cnt_d;
  logic              awready_q, awready_d, arready_q, arready_d;
  logic              wready_q, wready_d, bvalid_q, bvalid_d;
  logic [1:0]        bresp_q, bresp_d;
  logic              v1_q, v1_d, l1_q, l1_d;
  logic              aw_hs, ar_hs, w_hs, mem_we, adv;
  logic              out_v, out_l;
  logic [31:0]       out_d;
  logic [ADDR_W-1:0] addr_sel;
  logic [1:0]        burst_sel;
  logic [31:0]       ram_q;
  logic [31:0]       mem [MEM_WORDS];

  assign aw_hs   = s_axi.awvalid & awready_q;
  assign ar_hs   = s_axi.arvalid & arready_q & ~s_axi.awvalid;
  assign w_hs    = s_axi.wvalid & wready_q;
  assign mem_we  = w_hs & ~err_q & (cnt_q <= {1'b0, len_q});
  // Whole read pipeline (RAM register + optional output stage) stalls together,
  // so the held R beat stays stable and throughput is still one beat per clock.
  assign adv     = ~out_v | s_axi.rready;
  assign idx_nxt = (burst_q == BURST_FIXED) ? idx_q : idx_q + IDX_W'(1);

  always_comb begin
    state_d   = state_q;
    id_d      = id_q;
    len_d     = len_q;
    burst_d   = burst_q;
    idx_d     = idx_q;
    err_d     = err_q;
    cnt_d     = cnt_q;
    v1_d      = v1_q;
    l1_d      = l1_q;
    addr_sel  = aw_hs ? s_axi.awaddr : s_axi.araddr;
    burst_sel = aw_hs ? s_axi.awburst : s_axi.arburst;
    unique case (state_q)
      IDLE: if (aw_hs | ar_hs) begin
        id_d    = aw_hs ? s_axi.awid : s_axi.arid;
        len_d   = aw_hs ? s_axi.awlen : s_axi.arlen;
        burst_d = burst_sel;
        idx_d   = addr_sel[IDX_W+1:2];
        err_d   = ((addr_sel >> (IDX_W + 2)) != '0) | (burst_sel == BURST_WRAP) | (burst_sel == 2'b11);
        cnt_d   = '0;
        state_d = aw_hs ? WDATA : RADDR;
      end
      WDATA: if (w_hs) begin
        idx_d = idx_nxt;
        cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 9'd1;
        if (s_axi.wlast) begin
          if (cnt_q != {1'b0, len_q}) err_d = 1'b1;
          state_d = WRESP;
        end
      end
      WRESP: if (bvalid_q & s_axi.bready) state_d = IDLE;
      RADDR: if (adv) begin
        idx_d = idx_nxt;
        cnt_d = cnt_q + 9'd1;
        if (cnt_q[7:0] == len_q) state_d = RDATA;
      end
      RDATA: if (out_v & s_axi.rready & out_l) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (adv) begin
      v1_d = (state_q == RADDR);
      l1_d = (state_q == RADDR) & (cnt_q[7:0] == len_q);
    end
    awready_d = (state_d == IDLE);
    arready_d = (state_d == IDLE);
    wready_d  = (state_d == WDATA);
    bvalid_d  = (state_d == WRESP);
    bresp_d   = ((state_d == WRESP) && err_d) ? RESP_SLVERR : RESP_OKAY;
  end

  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) begin
      state_q   <= IDLE;
      id_q      <= '0;
      len_q     <= '0;
      burst_q   <= '0;
      idx_q     <= '0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
      awready_q <= 1'b0;
      arready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= '0;
      v1_q      <= 1'b0;
      l1_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      id_q      <= id_d;
      len_q     <= len_d;
      burst_q   <= burst_d;
      idx_q     <= idx_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
      awready_q <= awready_d;
      arready_q <= arready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      v1_q      <= v1_d;
      l1_q      <= l1_d;
    end
  end

  // RAM array carries no reset so it maps onto block RAM.
  always_ff @(posedge i_sys_clk) begin
    if (mem_we) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (s_axi.wstrb[b]) mem[idx_q][8*b +: 8] <= s_axi.wdata[8*b +: 8];
      end
    end
    if (adv) ram_q <= mem[idx_q];
  end

  if (RD_PIPE != 0) begin : g_pipe
    logic        v2_q, l2_q;
    logic [31:0] d2_q;
    always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
      if (!i_sys_rst_n) begin
        v2_q <= 1'b0;
        l2_q <= 1'b0;
        d2_q <= '0;
      end else if (adv) begin
        v2_q <= v1_q;
        l2_q <= l1_q;
        d2_q <= (v1_q & ~err_q) ? ram_q : '0;
      end
    end
    assign out_v = v2_q;
    assign out_l = l2_q;
    assign out_d = d2_q;
  end else begin : g_nopipe
    assign out_v = v1_q;
    assign out_l = l1_q;
    assign out_d = (v1_q & ~err_q) ? ram_q : '0;
  end

  assign s_axi.awready = awready_q;
  assign s_axi.arready = arready_q;
  assign s_axi.wready  = wready_q;
  assign s_axi.bvalid  = bvalid_q;
  assign s_axi.bresp   = bresp_q;
  assign s_axi.bid     = id_q;
  assign s_axi.rid     = id_q;
  assign s_axi.rvalid  = out_v;
  assign s_axi.rlast   = out_l;
  assign s_axi.rdata   = out_d;
  assign s_axi.rresp   = (out_v && err_q) ? RESP_SLVERR : RESP_OKAY;
endmodule

// File: tb/tb_axi_bram_responder.sv
// Directed bench for axi_bram_responder: INCR/FIXED bursts, AW/AR priority,
// R back-pressure, address/burst errors, byte strobes, index wrap, mid-read reset.
module tb_axi_bram_responder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;
  logic [31:0] wd [16];
  logic [31:0] ed [16];

  always #5 clk = ~clk;

  axi_bram_responder_if #(.ID_W(4), .ADDR_W(32)) s_axi ();

  axi_bram_responder #(
    .ID_W(4), .ADDR_W(32), .MEM_WORDS(1024), .RD_PIPE(1)
  ) dut (
    .i_sys_clk   (clk),
    .i_sys_rst_n (rst_n),
    .s_axi       (s_axi)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic aw(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst);
    int t = 0;
    s_axi.awid = id; s_axi.awaddr = addr; s_axi.awlen = len; s_axi.awburst = burst;
    s_axi.awvalid = 1'b1;
    while (!s_axi.awready && t < 50) begin @(negedge clk); t++; end
    chk("aw_ready", 32'(s_axi.awready), 32'd1);
    @(negedge clk);
    s_axi.awvalid = 1'b0;
  endtask

  task automatic w_burst(input int n, input logic [3:0] strb, input int last_at);
    for (int i = 0; i < n; i++) begin
      int t = 0;
      s_axi.wdata = wd[i]; s_axi.wstrb = strb; s_axi.wlast = (i == last_at); s_axi.wvalid = 1'b1;
      while (!s_axi.wready && t < 50) begin @(negedge clk); t++; end
      chk("w_ready", 32'(s_axi.wready), 32'd1);
      @(negedge clk);
    end
    s_axi.wvalid = 1'b0; s_axi.wlast = 1'b0;
  endtask

  task automatic b_check(input string tag, input logic [3:0] id, input logic [1:0] resp);
    int t = 0;
    s_axi.bready = 1'b1;
    while (!s_axi.bvalid && t < 50) begin @(negedge clk); t++; end
    chk({tag, "_bvalid"}, 32'(s_axi.bvalid), 32'd1);
    chk({tag, "_bid"}, 32'(s_axi.bid), 32'(id));
    chk({tag, "_bresp"}, 32'(s_axi.bresp), 32'(resp));
    @(negedge clk);
    s_axi.bready = 1'b0;
  endtask

  // AR handshake, then measure edges until the first rvalid (rready held low).
  task automatic ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst);
    int t = 0;
    int lat = 0;
    s_axi.rready = 1'b0;
    s_axi.arid = id; s_axi.araddr = addr; s_axi.arlen = len; s_axi.arburst = burst;
    s_axi.arvalid = 1'b1;
    while (!s_axi.arready && t < 50) begin @(negedge clk); t++; end
    chk("ar_ready", 32'(s_axi.arready), 32'd1);
    @(negedge clk);
    s_axi.arvalid = 1'b0;
    while (!s_axi.rvalid && lat < 50) begin @(negedge clk); lat++; end
    chk("r_latency", 32'(lat), 32'd2);
  endtask

  task automatic r_read(input string tag, input int n, input int stall, input logic [1:0] resp, input logic [3:0] id);
    int got = 0;
    int k = 0;
    int cyc = 0;
    bit done = 1'b0;
    bit hv = 1'b0;
    logic [31:0] hd = '0;
    chk({tag, "_rid"}, 32'(s_axi.rid), 32'(id));
    while (!done && cyc < 300) begin
      if (hv) begin
        chk({tag, "_hold_v"}, 32'(s_axi.rvalid), 32'd1);
        chk({tag, "_hold_d"}, s_axi.rdata, hd);
        hv = 1'b0;
      end
      s_axi.rready = (stall == 0) || (k % 3 == 0);
      k++;
      if (s_axi.rvalid) begin
        if (s_axi.rready) begin
          chk({tag, "_data"}, s_axi.rdata, ed[got % 16]);
          chk({tag, "_resp"}, 32'(s_axi.rresp), 32'(resp));
          chk({tag, "_last"}, 32'(s_axi.rlast), 32'(got == n - 1));
          got++;
          if (s_axi.rlast) done = 1'b1;
        end else begin
          hv = 1'b1;
          hd = s_axi.rdata;
        end
      end
      @(negedge clk);
      cyc++;
    end
    s_axi.rready = 1'b0;
    chk({tag, "_beats"}, 32'(got), 32'(n));
    chk({tag, "_rvalid_off"}, 32'(s_axi.rvalid), 32'd0);
  endtask

  initial begin
    s_axi.awid = '0; s_axi.awaddr = '0; s_axi.awlen = '0; s_axi.awburst = '0; s_axi.awvalid = 1'b0;
    s_axi.wdata = '0; s_axi.wstrb = '0; s_axi.wlast = 1'b0; s_axi.wvalid = 1'b0;
    s_axi.bready = 1'b0;
    s_axi.arid = '0; s_axi.araddr = '0; s_axi.arlen = '0; s_axi.arburst = '0; s_axi.arvalid = 1'b0;
    s_axi.rready = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_awready", 32'(s_axi.awready), 32'd0);
    chk("rst_arready", 32'(s_axi.arready), 32'd0);
    chk("rst_wready", 32'(s_axi.wready), 32'd0);
    chk("rst_bvalid", 32'(s_axi.bvalid), 32'd0);
    chk("rst_rvalid", 32'(s_axi.rvalid), 32'd0);
    chk("rst_rdata", s_axi.rdata, 32'd0);
    chk("rst_rlast", 32'(s_axi.rlast), 32'd0);
    chk("rst_bresp", 32'(s_axi.bresp), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_awready", 32'(s_axi.awready), 32'd1);
    chk("idle_arready", 32'(s_axi.arready), 32'd1);

    // INCR write 0x40 len 3, then read back
    for (int i = 0; i < 4; i++) wd[i] = 32'hA0 + i;
    aw(4'd5, 32'h40, 8'd3, 2'b01);
    w_burst(4, 4'hF, 3);
    b_check("incr_w", 4'd5, 2'b00);
    for (int i = 0; i < 4; i++) ed[i] = 32'hA0 + i;
    ar(4'd9, 32'h40, 8'd3, 2'b01);
    r_read("incr_r", 4, 0, 2'b00, 4'd9);

    // Simultaneous AW/AR: write first, then read sees the new data
    s_axi.awid = 4'd1; s_axi.awaddr = 32'h80; s_axi.awlen = 8'd0; s_axi.awburst = 2'b01;
    s_axi.arid = 4'd2; s_axi.araddr = 32'h80; s_axi.arlen = 8'd0; s_axi.arburst = 2'b01;
    s_axi.awvalid = 1'b1; s_axi.arvalid = 1'b1;
    @(negedge clk);
    s_axi.awvalid = 1'b0;
    chk("simul_arready_lo", 32'(s_axi.arready), 32'd0);
    wd[0] = 32'hDEADBEEF;
    w_burst(1, 4'hF, 0);
    chk("simul_arready_wresp", 32'(s_axi.arready), 32'd0);
    b_check("simul_w", 4'd1, 2'b00);
    ed[0] = 32'hDEADBEEF;
    ar(4'd2, 32'h80, 8'd0, 2'b01);
    r_read("simul_r", 1, 0, 2'b00, 4'd2);

    // 8-beat read under rready 1,0,0 back-pressure
    for (int i = 0; i < 8; i++) begin wd[i] = 32'h5500_0100 + i; ed[i] = 32'h5500_0100 + i; end
    aw(4'd3, 32'h100, 8'd7, 2'b01);
    w_burst(8, 4'hF, 7);
    b_check("stall_w", 4'd3, 2'b00);
    ar(4'd4, 32'h100, 8'd7, 2'b01);
    r_read("stall_r", 8, 1, 2'b00, 4'd4);

    // Byte strobes 0101 over all-ones
    wd[0] = 32'hFFFFFFFF;
    aw(4'd6, 32'h200, 8'd0, 2'b01);
    w_burst(1, 4'hF, 0);
    b_check("strb_w0", 4'd6, 2'b00);
    wd[0] = 32'h11223344;
    aw(4'd6, 32'h200, 8'd0, 2'b01);
    w_burst(1, 4'b0101, 0);
    b_check("strb_w1", 4'd6, 2'b00);
    ed[0] = 32'hFF22FF44;
    ar(4'd6, 32'h200, 8'd0, 2'b01);
    r_read("strb_r", 1, 0, 2'b00, 4'd6);

    // INCR starting at word 1023 wraps to word 0 (write and read)
    wd[0] = 32'hC0DE0001; wd[1] = 32'hC0DE0002;
    aw(4'd7, 32'hFFC, 8'd1, 2'b01);
    w_burst(2, 4'hF, 1);
    b_check("wrap_w", 4'd7, 2'b00);
    ed[0] = 32'hC0DE0002;
    ar(4'd7, 32'h0, 8'd0, 2'b01);
    r_read("wrap_r0", 1, 0, 2'b00, 4'd7);
    ed[0] = 32'hC0DE0001; ed[1] = 32'hC0DE0002;
    ar(4'd8, 32'hFFC, 8'd1, 2'b01);
    r_read("wrap_r", 2, 0, 2'b00, 4'd8);

    // Out-of-range address: SLVERR, word 0 untouched, read returns zero
    wd[0] = 32'h12345678;
    aw(4'hA, 32'h0000_1000, 8'd0, 2'b01);
    w_burst(1, 4'hF, 0);
    b_check("oor_w", 4'hA, 2'b10);
    ed[0] = 32'hC0DE0002;
    ar(4'hA, 32'h0, 8'd0, 2'b01);
    r_read("oor_ram", 1, 0, 2'b00, 4'hA);
    ed[0] = 32'h0;
    ar(4'hB, 32'h0000_1000, 8'd0, 2'b01);
    r_read("oor_r", 1, 0, 2'b10, 4'hB);

    // FIXED burst: only the last beat persists
    for (int i = 0; i < 4; i++) wd[i] = 32'hF0 + i;
    aw(4'hC, 32'h300, 8'd3, 2'b00);
    w_burst(4, 4'hF, 3);
    b_check("fixed_w", 4'hC, 2'b00);
    ed[0] = 32'hF3;
    ar(4'hC, 32'h300, 8'd0, 2'b01);
    r_read("fixed_r", 1, 0, 2'b00, 4'hC);

    // WRAP burst type rejected
    wd[0] = 32'h0BAD0BAD;
    aw(4'hD, 32'h400, 8'd0, 2'b10);
    w_burst(1, 4'hF, 0);
    b_check("wrapburst_w", 4'hD, 2'b10);

    // Early wlast on beat 1 of a 4-beat burst
    wd[0] = 32'h1; wd[1] = 32'h2;
    aw(4'hE, 32'h500, 8'd3, 2'b01);
    w_burst(2, 4'hF, 1);
    b_check("early_wlast", 4'hE, 2'b10);

    // Reset asserted mid-read
    ar(4'h3, 32'h100, 8'd7, 2'b01);
    chk("mid_rvalid_pre", 32'(s_axi.rvalid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rvalid_rst", 32'(s_axi.rvalid), 32'd0);
    chk("mid_arready_rst", 32'(s_axi.arready), 32'd0);
    @(negedge clk);
    chk("mid_rvalid_edge", 32'(s_axi.rvalid), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_arready_rel", 32'(s_axi.arready), 32'd1);
    chk("mid_rvalid_rel", 32'(s_axi.rvalid), 32'd0);
    for (int i = 0; i < 4; i++) ed[i] = 32'hA0 + i;
    ar(4'h1, 32'h40, 8'd3, 2'b01);
    r_read("post_rst_r", 4, 0, 2'b00, 4'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/axi_bram_responder.md
Name: axi_bram_responder

Overview:
- AXI4 slave memory responder backed by on-chip block RAM; the responding end of the AXI master port of the GMII Ethernet top.
- Drop-in stand-in for the DDR3 controller during bring-up and simulation.
- Services one burst at a time, with single-cycle-throughput beats on W and R.

Parameters:
ID_W, 4, AXI ID width
ADDR_W, 32, byte address width
MEM_WORDS, 1024, RAM depth in 32-bit words (power of 2); IDX_W = log2(MEM_WORDS)
RD_PIPE, 1, extra output register stages on RAM read (0 or 1)

Ports:
i_sys_clk  in  1  sole clock
i_sys_rst_n  in  1  reset, asynchronous assert, active-low
s_axi_awid  in  ID_W  write ID
s_axi_awaddr  in  ADDR_W  write start byte address
s_axi_awlen  in  8  beats-1
s_axi_awburst  in  2  00 FIXED, 01 INCR, 10 WRAP
s_axi_awvalid / s_axi_awready  in/out  1  AW handshake
s_axi_wdata  in  32  write data
s_axi_wstrb  in  4  byte enables
s_axi_wlast  in  1  last write beat
s_axi_wvalid / s_axi_wready  in/out  1  W handshake
s_axi_bid  out  ID_W  echoed awid
s_axi_bresp  out  2  00 OKAY, 10 SLVERR
s_axi_bvalid / s_axi_bready  out/in  1  B handshake
s_axi_arid  in  ID_W  read ID
s_axi_araddr  in  ADDR_W  read start byte address
s_axi_arlen  in  8  beats-1
s_axi_arburst  in  2  burst type
s_axi_arvalid / s_axi_arready  in/out  1  AR handshake
s_axi_rid  out  ID_W  echoed arid
s_axi_rdata  out  32  read data
s_axi_rresp  out  2  per-beat response
s_axi_rlast  out  1  last read beat
s_axi_rvalid / s_axi_rready  out/in  1  R handshake

Behaviour:
- Reset: all ready/valid outputs 0; bid, bresp, rid, rdata, rresp, rlast 0; FSM to IDLE. RAM contents undefined. Assertion mid-burst aborts the burst immediately; no B/R is issued afterwards.
- FSM: IDLE, WDATA, WRESP, RADDR, RDATA.
- IDLE:
  - awready = arready = 1 only in IDLE (registered).
  - Simultaneous AW and AR valid: AW wins; AR is taken on the next return to IDLE.
  - The handshake latches ID, len, burst, word index = addr[IDX_W+1:2] and err = (addr[ADDR_W-1:IDX_W+2] != 0) | (burst == WRAP) | (burst == 11).
- WDATA:
  - wready = 1 and a beat counter runs.
  - Each accepted beat writes the RAM byte-wise per wstrb when err = 0 and count <= len. Beats beyond len+1 are accepted but discarded.
  - INCR: index +1 per beat, wrapping modulo MEM_WORDS. FIXED: index held.
  - Exits on the beat with wlast = 1. If count != len at that beat, err is set.
- WRESP: bvalid = 1, bresp = err ? SLVERR : OKAY, bid = latched ID. Holds until bready; returns to IDLE on the handshake.
- RADDR/RDATA:
  - First rvalid is 1 + RD_PIPE cycles after the AR handshake.
  - With rready held high, beats are back-to-back with no bubbles. Skid/prefetch is required so throughput is 1 beat/clk.
  - Under rready = 0, rvalid, rdata, rlast and rresp are held stable.
  - rlast = 1 on beat len.
  - err = 1: rdata = 0 and rresp = SLVERR on every beat; the full len+1 beats are still returned.
  - Returns to IDLE after the rlast handshake.
- Only one transaction is outstanding, so IDs are merely echoed. awsize/arsize are not present; all beats are full 32-bit width.
- Sideband signals lock/cache/prot/qos are not ports.

Test Plan:
- INCR write awaddr 0x40, awlen 3, data A0..A3 with full strobes, then INCR read of the same range -> bresp 00, bid echoed; rdata A0..A3 with rlast on beat 3 only; first rvalid 2 clk after AR (RD_PIPE = 1).
- Simultaneous awvalid and arvalid in IDLE -> write completes with B before arready rises; read returns post-write data.
- Read awlen 7 with rready toggling 1,0,0,1,... -> no beat lost or duplicated; rdata stable across stalls; 8 beats, rlast once.
- awaddr 0x0000_1000 with MEM_WORDS 1024 -> bresp 10, RAM unchanged; araddr same -> 1 beat, rdata 0, rresp 10.
- Write with wstrb 0101 over 0xFFFFFFFF, data 0x11223344 -> readback 0xFF22FF44. INCR burst at index 1023, len 1 -> second beat lands at index 0. FIXED len 3 -> only the last beat persists.
- Early wlast (awlen 3, wlast on beat 1) -> bresp 10; reset pulsed mid-read -> rvalid 0 next edge, arready 1 after release.
